serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-004 Port clk  input  1  system clock; all logic rising-edge only.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port rxd  input  1  asynchronous serial line; idle high.
REQ-007 Port dout  output  8  byte at the FIFO head.
REQ-008 Port valid  output  1  high while the FIFO is not empty.
REQ-009 Port ready  input  1  consumer accepts dout in any cycle where valid && ready.
REQ-010 Port count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 Port frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity).
REQ-012 Port overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-013 rxd passes through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-014 Tick generator: counter pulses once every DIV = floor(CLK_HZ/(BAUD*16)) clocks (16x oversample); DIV < 1 is a parameter error.
REQ-015 FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-016 IDLE -> START on a synchronized falling edge; the tick-phase counter clears to 0 on entry.
REQ-017 START: after 8 ticks sample the line; low -> DATA; high -> IDLE (glitch rejected, nothing reported).
REQ-018 DATA: sample every 16 ticks, 8 bits, LSB first, shifted into an 8-bit register.
REQ-019 STOP: sample after 16 ticks; high -> push byte, go IDLE; low -> frame_err pulse, byte discarded, go WAIT_IDLE.
REQ-020 WAIT_IDLE -> IDLE once the synchronized line is high; no start detection in WAIT_IDLE.
REQ-021 FIFO is show-ahead: dout equals the head entry combinationally from the registered array; dout is don't-care while valid=0.
REQ-022 Pop on valid && ready; the next entry appears on dout in the following cycle.
REQ-023 Push while full with no simultaneous pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-024 Push while full with a simultaneous pop: both occur; count unchanged; no overrun.
REQ-025 Push while empty with ready=1: byte lands in the FIFO, valid rises the next cycle (no bypass), total latency stop-sample -> valid = 1 clock.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; count spans 0..FIFO_DEPTH.
REQ-027 overrun clears only on reset.

Reset
REQ-028 With reset high at a clock edge: FSM = IDLE, tick and bit counters = 0, shift register = 0, pointers and count = 0, valid = 0, frame_err = 0, overrun = 0.
REQ-029 Reset mid-frame abandons the frame with no push and no frame_err; reception resumes on the next falling edge after release.

Configuration
REQ-030 Macro SERIAL_RX_PARITY_EN defined: frames carry one even-parity bit after the data bits, sampled 16 ticks after bit 7.
REQ-031 With the macro, a parity mismatch pulses frame_err and discards the byte; the FSM still sampling STOP, then IDLE or WAIT_IDLE per REQ-019 (only one pulse per frame).
REQ-032 Macro undefined: no PARITY state and no parity logic; frames are 8N1.

Verification
REQ-033 8N1 0x55 at 115200 baud, ready=1 -> valid for exactly one cycle, dout=0x55, count 0->1->0.
REQ-034 Low pulse of 4 ticks on idle rxd -> no push, no frame_err, FSM back in IDLE.
REQ-035 Frame 0xA3 with stop bit driven low -> frame_err one-cycle pulse, count stays 0; next valid frame 0x3C received correctly after line returns high.
REQ-036 ready=0, send FIFO_DEPTH+1 bytes 0x00..0x10 -> count=16, overrun=1; then drain -> dout sequence 0x00..0x0F, 0x10 absent.
REQ-037 Assert reset during data bit 4 of 0xFF -> no push; next frame 0x81 received as 0x81.
REQ-038 SERIAL_RX_PARITY_EN defined: 0x07 with parity bit 1 -> accepted; same frame with parity bit 0 -> frame_err, no push.

Source files
------------

// File: rtl/serial_rx.sv
// UART receiver: 16x oversampled 8N1 front end feeding a show-ahead FIFO.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit after the data bits.
module serial_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [7:0]                    dout,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  if (DIV < 1) begin : g_div_err
    $error("serial_rx: CLK_HZ/(BAUD*16) must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT
  } state_t;

  logic          s1_q, s2_q, prev_q;
  logic          rx_s, fall;
  logic [DW-1:0] div_q;
  logic          tick;
  state_t        state_q;
  logic [3:0]    phase_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;
  logic          par_ok;
  logic          push, pop, full, do_push;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          overrun_q;

  // Line is idle-high, so the synchronizer and edge history reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rxd;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rx_s = s2_q;
  assign fall = prev_q & ~s2_q;
  assign tick = (div_q == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_q <= '0;
    else               div_q <= div_q + 1'b1;
  end

`ifdef SERIAL_RX_PARITY_EN
  logic perr_q;
  assign par_ok = ~perr_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q <= S_START;
            phase_q <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd7) begin
              phase_q <= '0;
              bit_q   <= '0;
`ifdef SERIAL_RX_PARITY_EN
              perr_q  <= 1'b0;
`endif
              state_q <= rx_s ? S_IDLE : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              shift_q <= {rx_s, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              perr_q  <= ^{rx_s, shift_q};
              state_q <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              frame_err_q <= ~rx_s | ~par_ok;
              state_q     <= rx_s ? S_IDLE : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte is written on the same edge the stop bit is sampled.
  assign push = (state_q == S_STOP) && tick && (phase_q == 4'd15)
              && rx_s && par_ok;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = valid && ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overrun_q <= 1'b1;
    end
  end

  assign dout      = mem_q[rptr_q];
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx at a reduced line rate (DIV=4).
// Good frames queue their byte; a negedge monitor pops and compares.
module tb_serial_rx;

  localparam int CLK_HZ = 6400000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic [4:0] count;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int valid_cyc = 0;
  int fe_cyc = 0;
  int fe_rise = 0;
  int max_cnt = 0;
  logic fe_prev = 1'b0;

  always #5 clk = ~clk;

  serial_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .dout(dout),
    .valid(valid),
    .ready(ready),
    .count(count),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) valid_cyc++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (frame_err) fe_cyc++;
      if (frame_err && !fe_prev) fe_rise++;
      fe_prev = frame_err;
      if (valid && ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected got=%h exp=none", dout);
        end else begin
          exp_b = sb.pop_front();
          if (dout !== exp_b) begin
            bad++;
            $display("FAIL pop_data got=%h exp=%h", dout, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input int rst_bit);
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == rst_bit) begin
        cyc(BIT / 2);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(BIT / 2 - 2);
      end else begin
        cyc(BIT);
      end
    end
`ifdef SERIAL_RX_PARITY_EN
    rxd = ^b;
    cyc(BIT);
`endif
    rxd = stop;
    cyc(BIT);
    rxd = 1'b1;
    cyc(BIT);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(4);
    chk("reset_valid", int'(valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic;
    int v0, f0;
    v0 = valid_cyc;
    f0 = fe_cyc;
    max_cnt = 0;
    sb.push_back(8'h55);
    send(8'h55, 1'b1, -1);
    chk("basic_valid_cycles", valid_cyc - v0, 1);
    chk("basic_max_count", max_cnt, 1);
    chk("basic_count_end", int'(count), 0);
    chk("basic_sb_empty", sb.size(), 0);
    chk("basic_no_ferr", fe_cyc - f0, 0);
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cyc;
    f0 = fe_cyc;
    rxd = 1'b0;
    cyc(4 * DIV);
    rxd = 1'b1;
    cyc(3 * BIT);
    chk("glitch_no_ferr", fe_cyc - f0, 0);
    chk("glitch_no_valid", valid_cyc - v0, 0);
    chk("glitch_count", int'(count), 0);
    sb.push_back(8'h5A);
    send(8'h5A, 1'b1, -1);
    chk("glitch_next_sb", sb.size(), 0);
  endtask

  task automatic test_frame_err;
    int v0, f0, r0;
    v0 = valid_cyc;
    f0 = fe_cyc;
    r0 = fe_rise;
    send(8'hA3, 1'b0, -1);
    chk("ferr_cycles", fe_cyc - f0, 1);
    chk("ferr_pulses", fe_rise - r0, 1);
    chk("ferr_count", int'(count), 0);
    chk("ferr_no_valid", valid_cyc - v0, 0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1, -1);
    chk("ferr_next_sb", sb.size(), 0);
  endtask

  task automatic test_overrun;
    logic [7:0] b;
    ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(i);
      if (i < DEPTH) sb.push_back(b);
      send(b, 1'b1, -1);
    end
    chk("ovr_count_full", int'(count), DEPTH);
    chk("ovr_flag", int'(overrun), 1);
    ready = 1'b1;
    cyc(DEPTH + 4);
    chk("ovr_drained", int'(count), 0);
    chk("ovr_sb_empty", sb.size(), 0);
    chk("ovr_sticky", int'(overrun), 1);
  endtask

  task automatic test_reset_mid;
    int v0, f0;
    v0 = valid_cyc;
    f0 = fe_cyc;
    send(8'hFF, 1'b1, 4);
    chk("rmid_overrun_clr", int'(overrun), 0);
    chk("rmid_count", int'(count), 0);
    chk("rmid_no_ferr", fe_cyc - f0, 0);
    chk("rmid_no_valid", valid_cyc - v0, 0);
    sb.push_back(8'h81);
    send(8'h81, 1'b1, -1);
    chk("rmid_next_sb", sb.size(), 0);
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic pbit);
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(BIT);
    end
    rxd = pbit;
    cyc(BIT);
    rxd = 1'b1;
    cyc(2 * BIT);
  endtask

  task automatic test_parity;
    int v0, f0;
    f0 = fe_cyc;
    sb.push_back(8'h07);
    send_par(8'h07, 1'b1);
    chk("par_ok_sb", sb.size(), 0);
    chk("par_ok_no_ferr", fe_cyc - f0, 0);
    v0 = valid_cyc;
    f0 = fe_cyc;
    send_par(8'h07, 1'b0);
    chk("par_bad_ferr", fe_cyc - f0, 1);
    chk("par_bad_no_valid", valid_cyc - v0, 0);
    chk("par_bad_count", int'(count), 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
